seg_display_scan: RTL

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/bin2bcd_seq.sv | 57 +++++
 rtl/seg_display_scan.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types, glyph constants and FSM state encoding for the 7-segment scanner.
package seg_pkg;

   typedef logic [6:0] seg7_t;   // active-low {g,f,e,d,c,b,a}

   localparam seg7_t SEG_BLANK = 7'b1111111;
   localparam seg7_t SEG_MINUS = 7'b0111111;
   localparam seg7_t SEG_E     = 7'b0000110;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   // Hex digit to active-low segment pattern.
   function automatic seg7_t seg_glyph(input logic [3:0] v);
      seg7_t g;
      case (v)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0011000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock,
// exactly DATA_W steps after a start pulse. o_done is high during the last step.
module bin2bcd_seq #(
   parameter int DATA_W     = 32,
   parameter int BCD_DIGITS = 11
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic [DATA_W-1:0]       i_bin,
   output logic                    o_done,
   output logic [4*BCD_DIGITS-1:0] o_bcd
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int BW    = 4 * BCD_DIGITS;

   logic [DATA_W-1:0] r_bin;
   logic [BW-1:0]     r_bcd;
   logic [BW-1:0]     w_adj;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_run;
   logic              w_unused_msb;

   // Add 3 to every BCD nibble that is 5 or more before the shift.
   for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
      assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                          : r_bcd[4*i +: 4];
   end

   // The top nibble never carries out because BCD_DIGITS covers the full range.
   assign w_unused_msb = w_adj[BW-1];

   // Load on start, then shift one binary bit into the BCD register per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_start) begin
         r_bin <= i_bin;
         r_bcd <= '0;
         r_cnt <= CNT_W'(DATA_W);
         r_run <= 1'b1;
      end else if (r_run) begin
         r_bin <= {r_bin[DATA_W-2:0], 1'b0};
         r_bcd <= {w_adj[BW-2:0], r_bin[DATA_W-1]};
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == CNT_W'(1)) r_run <= 1'b0;
      end
   end

   assign o_done = r_run && (r_cnt == CNT_W'(1));
   assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment driver: captures a value on load, converts it to
// decimal (signed or unsigned) or hex digits, then scans the digits out.
module seg_display_scan
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DATA_W      = 32,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  load,
   input  logic                  hex_mode,
   input  logic                  signed_mode,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic [6:0]            seg_n,
   output logic [NUM_DIGITS-1:0] an_n
);

   localparam int BCD_D  = (DATA_W * 302 + 999) / 1000 + 1;
   localparam int SCAN_W = $clog2(REFRESH_DIV);
   localparam int IDX_W  = $clog2(NUM_DIGITS);

   state_t r_state, w_state_nxt;

   logic                  r_hex, r_neg, r_blz;
   logic [DATA_W-1:0]     r_mag;
   logic                  w_neg, w_start, w_done, w_ovf;
   logic [DATA_W-1:0]     w_mag;
   logic [4*BCD_D-1:0]    w_bcd;
   logic [63:0]           w_src;
   logic [4:0]            w_nd;

   logic [NUM_DIGITS-1:0][6:0] w_disp, r_dig;

   logic [SCAN_W-1:0]     r_scan;
   logic [IDX_W-1:0]      r_idx, w_idx_nxt;
   logic [NUM_DIGITS-1:0] r_an;
   seg7_t                 r_seg;

   assign w_neg   = signed_mode & ~hex_mode & data_in[DATA_W-1];
   assign w_mag   = w_neg ? (~data_in + 1'b1) : data_in;
   assign w_start = (r_state == ST_IDLE) && load;

   bin2bcd_seq #(.DATA_W(DATA_W), .BCD_DIGITS(BCD_D)) u_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_start & ~hex_mode),
      .i_bin   (w_mag),
      .o_done  (w_done),
      .o_bcd   (w_bcd)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: hex needs a single CONVERT cycle, decimal waits for the converter.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (load) w_state_nxt = ST_CONVERT;
         ST_CONVERT: if (r_hex || w_done) w_state_nxt = ST_COMMIT;
         ST_COMMIT:  w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (r_state != ST_IDLE);

   // Capture the mode bits and magnitude when a load is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hex <= 1'b0;
         r_neg <= 1'b0;
         r_blz <= 1'b0;
         r_mag <= '0;
      end else if (w_start) begin
         r_hex <= hex_mode;
         r_neg <= w_neg;
         r_blz <= blank_lz;
         r_mag <= w_mag;
      end
   end

   // Both hex and BCD results are nibble vectors; pad to a common width.
   assign w_src = r_hex ? 64'(r_mag) : 64'(w_bcd);

   // Count of significant digits (at least one, so zero still shows "0").
   always_comb begin
      w_nd = 5'd1;
      for (int i = 0; i < 16; i++)
         if (w_src[4*i +: 4] != 4'd0) w_nd = 5'(i + 1);
   end

   // A negative value reserves one digit position for the minus sign.
   assign w_ovf = w_nd > (5'(NUM_DIGITS) - 5'(r_neg));

   // Build the glyph for every digit position from the converted value.
   always_comb begin
      w_disp = {NUM_DIGITS{SEG_BLANK}};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_ovf)
            w_disp[i] = SEG_E;
         else if (5'(i) < w_nd)
            w_disp[i] = seg_glyph(w_src[4*i +: 4]);
         else if (r_neg && (5'(i) == (r_blz ? w_nd : 5'(NUM_DIGITS - 1))))
            w_disp[i] = SEG_MINUS;
         else if (!r_blz)
            w_disp[i] = seg_glyph(4'd0);
      end
   end

   // Digit registers only change in COMMIT and hold until the next one.
   always_ff @(posedge clk) begin
      if (!rst_n)                    r_dig <= {NUM_DIGITS{SEG_BLANK}};
      else if (r_state == ST_COMMIT) r_dig <= w_disp;
   end

   assign w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;

   // Scan timer: on each slot wrap select the next digit and latch its glyph.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_scan <= '0;
         r_idx  <= '0;
         r_an   <= ~NUM_DIGITS'(1);
         r_seg  <= SEG_BLANK;
      end else if (r_scan == SCAN_W'(REFRESH_DIV - 1)) begin
         r_scan <= '0;
         r_idx  <= w_idx_nxt;
         r_an   <= ~(NUM_DIGITS'(1) << w_idx_nxt);
         r_seg  <= r_dig[w_idx_nxt];
      end else begin
         r_scan <= r_scan + 1'b1;
      end
   end

   assign an_n  = r_an;
   assign seg_n = r_seg;

endmodule
